// File: rtl/snoop_capture.sv
// snoop_capture: passive AXI-Stream snooper that turns each accepted packet
// into sequential packet-memory word writes, then raises done until ack.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   sn_TDATA/TKEEP/TVALID/
//   sn_TREADY/TLAST          snooped stream (all inputs; TREADY never driven)
//   addr, wr_data, wr_en,
//   byte_inc                 registered packet-memory write port
//   done / ack               end-of-packet handshake with the arbiter
//   rdy                      arbiter has a free buffer (sampled at packet start)
module snoop_capture #(
  parameter int SN_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int INC_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    sn_TDATA,
  input  logic [DATA_WIDTH/8-1:0]  sn_TKEEP,
  input  logic                     sn_TVALID,
  input  logic                     sn_TREADY,
  input  logic                     sn_TLAST,
  output logic [SN_ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_en,
  output logic [INC_WIDTH-1:0]     byte_inc,
  output logic                     done,
  input  logic                     ack,
  input  logic                     rdy
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RECV, WAIT_ACK, DROP} state_t;

  state_t                   state_q, state_d;
  logic                     sof_q, sof_d;
  logic                     full_q, full_d;
  logic                     drop_pend_q, drop_pend_d;
  logic [SN_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     wr_en_q, wr_en_d;
  logic [INC_WIDTH-1:0]     byte_inc_q, byte_inc_d;
  logic                     done_q, done_d;

  logic                     beat;
  logic                     store;
  logic [SN_ADDR_WIDTH-1:0] store_addr;
  logic [INC_WIDTH-1:0]     keep_cnt;

  assign beat = sn_TVALID && sn_TREADY;

  always_comb begin
    keep_cnt = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      keep_cnt = keep_cnt + INC_WIDTH'(sn_TKEEP[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    sof_d       = beat ? sn_TLAST : sof_q;
    full_d      = full_q;
    drop_pend_d = drop_pend_q;
    store       = 1'b0;
    store_addr  = addr_q;

    case (state_q)
      IDLE: begin
        if (beat && sof_q) begin
          if (rdy) begin
            store      = 1'b1;
            store_addr = '0;
            full_d     = 1'b0;
            state_d    = sn_TLAST ? WAIT_ACK : RECV;
          end else begin
            state_d    = sn_TLAST ? IDLE : DROP;
          end
        end
      end
      RECV: begin
        if (beat) begin
          // Once the top word is written the buffer is full; later beats
          // (including TLAST) are discarded but the packet still completes.
          if (!full_q) begin
            store      = 1'b1;
            store_addr = addr_q + SN_ADDR_WIDTH'(1);
            full_d     = &store_addr;
          end
          if (sn_TLAST) state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A packet starting here is dropped; remember whether it is still
        // open when ack arrives so its tail is swallowed in DROP.
        if (beat) drop_pend_d = !sn_TLAST;
        if (ack) begin
          state_d     = drop_pend_d ? DROP : IDLE;
          drop_pend_d = 1'b0;
        end
      end
      DROP: begin
        if (beat && sn_TLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_en_d    = store;
    addr_d     = store ? store_addr : addr_q;
    wr_data_d  = store ? sn_TDATA   : wr_data_q;
    byte_inc_d = store ? keep_cnt   : byte_inc_q;
    done_d     = (state_d == WAIT_ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sof_q       <= 1'b1;
      full_q      <= 1'b0;
      drop_pend_q <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      byte_inc_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sof_q       <= sof_d;
      full_q      <= full_d;
      drop_pend_q <= drop_pend_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      byte_inc_q  <= byte_inc_d;
      done_q      <= done_d;
    end
  end

  assign addr     = addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign byte_inc = byte_inc_q;
  assign done     = done_q;

endmodule

// File: tb/tb_snoop_capture.sv
// Directed bench for snoop_capture: a default-size instance plus a
// 4-word instance (SN_ADDR_WIDTH=2) sharing the same stream stimulus.
module tb_snoop_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tready, tlast, ack, rdy;

  logic [7:0]  addr0;
  logic [63:0] wr_data0;
  logic        wr_en0, done0;
  logic [7:0]  byte_inc0;

  logic [1:0]  addr1;
  logic [63:0] wr_data1;
  logic        wr_en1, done1;
  logic [7:0]  byte_inc1;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  snoop_capture #(.SN_ADDR_WIDTH(8), .DATA_WIDTH(64), .INC_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst),
    .sn_TDATA(tdata), .sn_TKEEP(tkeep), .sn_TVALID(tvalid),
    .sn_TREADY(tready), .sn_TLAST(tlast),
    .addr(addr0), .wr_data(wr_data0), .wr_en(wr_en0), .byte_inc(byte_inc0),
    .done(done0), .ack(ack), .rdy(rdy)
  );

  snoop_capture #(.SN_ADDR_WIDTH(2), .DATA_WIDTH(64), .INC_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst),
    .sn_TDATA(tdata), .sn_TKEEP(tkeep), .sn_TVALID(tvalid),
    .sn_TREADY(tready), .sn_TLAST(tlast),
    .addr(addr1), .wr_data(wr_data1), .wr_en(wr_en1), .byte_inc(byte_inc1),
    .done(done1), .ack(ack), .rdy(rdy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic r, input logic l,
                     input logic [7:0] k, input logic [63:0] d);
    tvalid = v; tready = r; tlast = l; tkeep = k; tdata = d;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
  endtask

  // Expected outputs of the default-size instance.
  task automatic exp0(input string tag, input logic we, input logic [7:0] a,
                      input logic [7:0] bi, input logic dn, input logic [63:0] d);
    chk({tag, ".wr_en"}, 64'(wr_en0), 64'(we));
    chk({tag, ".addr"},  64'(addr0),  64'(a));
    chk({tag, ".done"},  64'(done0),  64'(dn));
    if (we) begin
      chk({tag, ".byte_inc"}, 64'(byte_inc0), 64'(bi));
      chk({tag, ".wr_data"},  wr_data0,       d);
    end
  endtask

  // Expected outputs of the 4-word instance.
  task automatic exp1(input string tag, input logic we, input logic [1:0] a,
                      input logic dn);
    chk({tag, ".wr_en1"}, 64'(wr_en1), 64'(we));
    chk({tag, ".addr1"},  64'(addr1),  64'(a));
    chk({tag, ".done1"},  64'(done1),  64'(dn));
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    chk({tag, ".done_pre"}, 64'(done0), 64'd1);
    tick();
    ack = 1'b0;
    chk({tag, ".done_post"},  64'(done0), 64'd0);
    chk({tag, ".done1_post"}, 64'(done1), 64'd0);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; rdy = 1'b1;
    idle();
    tick();
    exp0("rst", 1'b0, 8'd0, 8'd0, 1'b0, 64'h0);
    chk("rst.wr_data", wr_data0, 64'h0);
    chk("rst.byte_inc", 64'(byte_inc0), 64'h0);
    exp1("rst", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    tick();

    // Basic 3-beat packet
    drv(1, 1, 0, 8'hFF, 64'hA1A1_0000_0000_0001); tick();
    exp0("p1b1", 1, 8'd0, 8'd8, 0, 64'hA1A1_0000_0000_0001);
    exp1("p1b1", 1, 2'd0, 0);
    drv(1, 1, 0, 8'hFF, 64'hA1A1_0000_0000_0002); tick();
    exp0("p1b2", 1, 8'd1, 8'd8, 0, 64'hA1A1_0000_0000_0002);
    drv(1, 1, 1, 8'h0F, 64'h0000_0000_DEAD_BEEF); tick();
    exp0("p1b3", 1, 8'd2, 8'd4, 1, 64'h0000_0000_DEAD_BEEF);
    exp1("p1b3", 1, 2'd2, 1);
    idle(); tick();
    exp0("p1w", 0, 8'd2, 8'd0, 1, 64'h0);
    do_ack("p1ack");

    // rdy low at packet start drops the whole packet
    rdy = 1'b0;
    drv(1, 1, 0, 8'hFF, 64'h11); tick();
    exp0("p2b1", 0, 8'd2, 8'd0, 0, 64'h0);
    rdy = 1'b1;
    drv(1, 1, 0, 8'hFF, 64'h12); tick();
    exp0("p2b2", 0, 8'd2, 8'd0, 0, 64'h0);
    drv(1, 1, 0, 8'hFF, 64'h13); tick();
    exp0("p2b3", 0, 8'd2, 8'd0, 0, 64'h0);
    drv(1, 1, 1, 8'hFF, 64'h14); tick();
    exp0("p2b4", 0, 8'd2, 8'd0, 0, 64'h0);
    drv(1, 1, 1, 8'h03, 64'h0000_0000_0000_BEEF); tick();
    exp0("p3b1", 1, 8'd0, 8'd2, 1, 64'h0000_0000_0000_BEEF);
    idle();
    do_ack("p3ack");

    // 6-beat packet: overflows the 4-word instance
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, (i == 5), 8'hFF, 64'(100 + i)); tick();
      if (i < 4) exp1($sformatf("ovf%0d", i), 1, 2'(i), 0);
      else       exp1($sformatf("ovf%0d", i), 0, 2'd3, (i == 5));
    end
    exp0("ovf_big", 1, 8'd5, 8'd8, 1, 64'd105);
    idle(); tick();
    exp1("ovf_hold", 0, 2'd3, 1);
    do_ack("ovfack");

    // Stall cycles mid-packet
    drv(1, 1, 0, 8'hFF, 64'h21); tick();
    exp0("st1", 1, 8'd0, 8'd8, 0, 64'h21);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 8'hFF, 64'h99); tick();
      exp0($sformatf("stall%0d", i), 0, 8'd0, 8'd0, 0, 64'h0);
    end
    drv(1, 1, 0, 8'h7F, 64'h22); tick();
    exp0("st2", 1, 8'd1, 8'd7, 0, 64'h22);
    drv(1, 1, 1, 8'h01, 64'h23); tick();
    exp0("st3", 1, 8'd2, 8'd1, 1, 64'h23);
    idle();
    do_ack("stack");

    // New packet while done is held: dropped; ack mid-packet moves to DROP
    drv(1, 1, 1, 8'hFF, 64'h31); tick();
    exp0("wa_a", 1, 8'd0, 8'd8, 1, 64'h31);
    drv(1, 1, 0, 8'hFF, 64'h41); tick();
    exp0("wa_b1", 0, 8'd0, 8'd0, 1, 64'h0);
    drv(1, 1, 0, 8'hFF, 64'h42); ack = 1'b1; tick(); ack = 1'b0;
    exp0("wa_b2", 0, 8'd0, 8'd0, 0, 64'h0);
    drv(1, 1, 1, 8'hFF, 64'h43); tick();
    exp0("wa_b3", 0, 8'd0, 8'd0, 0, 64'h0);
    drv(1, 1, 0, 8'h3F, 64'h51); tick();
    exp0("wa_c1", 1, 8'd0, 8'd6, 0, 64'h51);
    drv(1, 1, 1, 8'hFF, 64'h52); tick();
    exp0("wa_c2", 1, 8'd1, 8'd8, 1, 64'h52);
    idle();
    do_ack("waack");

    // Reset mid-packet
    drv(1, 1, 0, 8'hFF, 64'h61); tick();
    exp0("rm1", 1, 8'd0, 8'd8, 0, 64'h61);
    drv(1, 1, 0, 8'hFF, 64'h62); tick();
    exp0("rm2", 1, 8'd1, 8'd8, 0, 64'h62);
    drv(1, 1, 0, 8'hFF, 64'h63);
    rst = 1'b1; #1;
    exp0("rm_async", 0, 8'd0, 8'd0, 0, 64'h0);
    chk("rm_async.wr_data", wr_data0, 64'h0);
    tick();
    rst = 1'b0;
    rdy = 1'b0;
    drv(1, 1, 0, 8'hFF, 64'h64); tick();
    exp0("rm4", 0, 8'd0, 8'd0, 0, 64'h0);
    rdy = 1'b1;
    drv(1, 1, 1, 8'hFF, 64'h65); tick();
    exp0("rm5", 0, 8'd0, 8'd0, 0, 64'h0);
    drv(1, 1, 1, 8'h1F, 64'h71); tick();
    exp0("rm_next", 1, 8'd0, 8'd5, 1, 64'h71);
    idle();
    do_ack("rmack");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
